// File: rtl/goofy_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : goofy_alu_pkg
// Purpose  : Shared types for the goofy_alu_seq datapath unit: opcode
//            encoding, control FSM state and the status-flag bundle.
// Contents : OP_W    - opcode width
//            op_e    - opcode enumeration (13..15 are reserved)
//            state_e - control FSM states (MUL only used with GOOFY_ALU_MUL_EN)
//            flags_t - {c, z, eq, hlt} flag bundle
// Revision : 1.0 - initial release
// ============================================================================
package goofy_alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_CMP = 4'd10,
    OP_HLT = 4'd11,
    OP_MUL = 4'd12
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic eq;
    logic hlt;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/goofy_alu_mul.sv
`default_nettype none
// ============================================================================
// Module   : goofy_alu_mul
// Purpose  : Iterative unsigned shift-add multiplier, one partial product per
//            clock, WIDTH iterations per multiply.
// Ports    : clk        - clock, rising edge
//            rst_ni     - asynchronous active-low reset (aborts a multiply)
//            start_i    - capture a_i/b_i and begin
//            a_i, b_i   - multiplicand / multiplier
//            done_o     - high during the last iteration cycle
//            product_o  - full 2*WIDTH product, valid while done_o is high
// Revision : 1.0 - initial release
// ============================================================================
module goofy_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  // {partial high word, remaining multiplier bits}; shifts right each step.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     add_w;

  always_comb begin
    add_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {add_w, acc_q[WIDTH-1:1]};
  end

  // The final step is exposed combinationally so the owner can register the
  // product on the same edge that completes it.
  assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      mcand_q <= a_i;
      acc_q   <= {{WIDTH{1'b0}}, b_i};
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/goofy_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : goofy_alu_seq
// Purpose  : Handshaked ALU with two operand registers, single-cycle ops and
//            an optional iterative unsigned multiply. Results, flags and the
//            completion pulse are registered.
// Config   : GOOFY_ALU_MUL_EN - when defined, opcode 12 runs the WIDTH-cycle
//            multiplier; otherwise it is reserved and result_hi is 0.
// Ports    : clk, res (async active-low reset)
//            a_we/b_we, a_d/b_d   - operand register writes
//            a_o/b_o              - operand register contents
//            op_valid/op_ready/op - op request handshake
//            res_valid            - one-cycle pulse per accepted op
//            result/result_hi     - result word / MUL high word
//            flag_c/z/eq/hlt      - status flags, flag_clr clears them
// Revision : 1.0 - initial release
// ============================================================================
module goofy_alu_seq
  import goofy_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             a_we,
  input  logic             b_we,
  input  logic [WIDTH-1:0] a_d,
  input  logic [WIDTH-1:0] b_d,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_eq,
  output logic             flag_hlt,
  input  logic             flag_clr
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  flags_t           flags_q, flags_d;
  logic             res_valid_q, res_valid_d;
  logic             accept;
  logic             wr_res;
  logic             clr_hi;
  logic [WIDTH:0]   arith;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;

  assign accept = op_valid && op_ready;
  assign shamt  = b_q[SHW-1:0];
  // One guard bit on the exit side captures the last bit shifted out; it is
  // naturally 0 for a zero shift amount.
  assign shl_w  = {1'b0, a_q} << shamt;
  assign shr_w  = {a_q, 1'b0} >> shamt;

`ifdef GOOFY_ALU_MUL_EN
  state_e             state_q;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  goofy_alu_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_ni    (res),
    .start_i   (mul_start),
    .a_i       (a_q),
    .b_i       (b_q),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign op_ready = (state_q == ST_IDLE) && !flags_q.hlt;
`else
  assign op_ready = !flags_q.hlt;
`endif

  always_comb begin
    flags_d     = flags_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    res_valid_d = 1'b0;
    arith       = '0;
    wr_res      = 1'b0;
    clr_hi      = 1'b0;
`ifdef GOOFY_ALU_MUL_EN
    mul_start   = 1'b0;
`endif

    // Clear first so that flag writes of a same-edge op take priority.
    if (flag_clr) begin
      flags_d = '0;
    end

    if (accept) begin
      res_valid_d = 1'b1;
      case (op)
        OP_ADD, OP_ADC: begin
          arith     = {1'b0, a_q} + {1'b0, b_q}
                    + {{WIDTH{1'b0}}, (op == OP_ADC) && flags_q.c};
          result_d  = arith[WIDTH-1:0];
          flags_d.c = arith[WIDTH];
          wr_res    = 1'b1;
          clr_hi    = 1'b1;
        end
        OP_SUB, OP_SBC: begin
          // Top bit of the (WIDTH+1)-bit difference is the borrow.
          arith     = {1'b0, a_q} - {1'b0, b_q}
                    - {{WIDTH{1'b0}}, (op == OP_SBC) && flags_q.c};
          result_d  = arith[WIDTH-1:0];
          flags_d.c = arith[WIDTH];
          wr_res    = 1'b1;
          clr_hi    = 1'b1;
        end
        OP_AND: begin
          result_d = a_q & b_q;
          wr_res   = 1'b1;
          clr_hi   = 1'b1;
        end
        OP_OR: begin
          result_d = a_q | b_q;
          wr_res   = 1'b1;
          clr_hi   = 1'b1;
        end
        OP_XOR: begin
          result_d = a_q ^ b_q;
          wr_res   = 1'b1;
          clr_hi   = 1'b1;
        end
        OP_NOT: begin
          result_d = ~a_q;
          wr_res   = 1'b1;
          clr_hi   = 1'b1;
        end
        OP_SHL: begin
          result_d  = shl_w[WIDTH-1:0];
          flags_d.c = shl_w[WIDTH];
          wr_res    = 1'b1;
          clr_hi    = 1'b1;
        end
        OP_SHR: begin
          result_d  = shr_w[WIDTH:1];
          flags_d.c = shr_w[0];
          wr_res    = 1'b1;
          clr_hi    = 1'b1;
        end
        OP_CMP: begin
          flags_d.eq = (a_q == b_q);
          flags_d.c  = (a_q < b_q);
          clr_hi     = 1'b1;
        end
        OP_HLT: begin
          flags_d.hlt = 1'b1;
          clr_hi      = 1'b1;
        end
`ifdef GOOFY_ALU_MUL_EN
        OP_MUL: begin
          // Completion pulse comes from the multiplier, not the accept.
          res_valid_d = 1'b0;
          mul_start   = 1'b1;
        end
`endif
        default: begin
        end
      endcase
      if (wr_res) begin
        flags_d.z = (result_d == '0);
      end
      if (clr_hi) begin
        result_hi_d = '0;
      end
    end

`ifdef GOOFY_ALU_MUL_EN
    // Never coincides with an accept: op_ready is low while multiplying.
    if (mul_done) begin
      res_valid_d              = 1'b1;
      {result_hi_d, result_d}  = mul_prod;
      flags_d.c                = |mul_prod[2*WIDTH-1:WIDTH];
      flags_d.z                = ~|mul_prod;
    end
`endif
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      res_valid_q <= 1'b0;
`ifdef GOOFY_ALU_MUL_EN
      state_q     <= ST_IDLE;
`endif
    end else begin
      if (a_we) begin
        a_q <= a_d;
      end
      if (b_we) begin
        b_q <= b_d;
      end
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
`ifdef GOOFY_ALU_MUL_EN
      case (state_q)
        ST_IDLE: if (mul_start) state_q <= ST_MUL;
        ST_MUL:  if (mul_done)  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
`endif
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_eq   = flags_q.eq;
  assign flag_hlt  = flags_q.hlt;

endmodule
`default_nettype wire

// File: doc/goofy_alu_seq.md
# goofy_alu_seq

Parametrised, handshaked successor to the GoofyALU, sitting between the control unit and the register/bus datapath. It holds two WIDTH-bit operand registers and executes single-cycle ops (add/sub with carry, logic, shifts, compare, halt) plus an optional multi-cycle unsigned multiply. Results, flags and a one-cycle completion pulse are all registered. The control unit sequences work with a valid/ready handshake instead of one-hot strobes.

## Interface
- WIDTH, 8: operand/result width; power of two, ≥4.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  in  1  system clock, all state on rising edge.
- res  in  1  asynchronous, active-low reset.
- a_we / b_we  in  1  load operand A / B from a_d / b_d at the clock edge.
- a_d / b_d  in  WIDTH  operand write data.
- a_o / b_o  out  WIDTH  current operand register contents.
- op_valid  in  1  op request; op_ready  out  1  unit can accept.
- op  in  4  opcode (goofy_alu_pkg).
- res_valid  out  1  one-cycle pulse per accepted op.
- result  out  WIDTH  low/only result word; result_hi  out  WIDTH  MUL high word.
- flag_c, flag_z, flag_eq, flag_hlt  out  1 each.
- flag_clr  in  1  clear all four flags.

## Operation
- Accept = op_valid && op_ready at a rising edge. Operands used are the register values before that edge; a simultaneous a_we/b_we lands afterwards.
- Opcodes: 0 ADD, 1 ADC (+C), 2 SUB, 3 SBC (−C), 4 AND, 5 OR, 6 XOR, 7 NOT (~A), 8 SHL, 9 SHR, 10 CMP, 11 HLT, 12 MUL, 13–15 reserved.
- ADD/ADC: C = carry out of bit WIDTH−1. SUB/SBC: C = borrow. C is overwritten, not sticky.
- SHL/SHR: logical shift of A by B[SHW−1:0]. C = last bit shifted out, or 0 for amount 0.
- Logic ops: C unchanged.
- Every result-producing op writes result and sets Z = (result == 0). result_hi is cleared for all ops except MUL.
- CMP: eq = (A == B); C = (A < B) unsigned. result and Z are unchanged.
- HLT: sets flag_hlt. While flag_hlt = 1, op_ready = 0.
- MUL: unsigned shift-add over WIDTH cycles. {result_hi, result} = A*B; C = (result_hi != 0); Z = full product == 0.
- Every accepted op, reserved opcodes included, pulses res_valid once. Reserved opcodes change nothing else.
- flag_clr together with an accepting edge: clear first, then the op's flag writes apply (op wins). flag_clr during MUL clears flags; the MUL completion writes them again.
- FSM: IDLE → (accept MUL) → MUL → (WIDTH iterations done) → IDLE. op_ready = (state == IDLE) && !flag_hlt.

## Timing
- Reset (asynchronous, immediate): all registers, result, result_hi, flags and res_valid go to 0; state = IDLE; op_ready = 1 once res deasserts.
- Reset during MUL aborts it; no res_valid is produced.
- Single-cycle op accepted at edge E: result, flags and res_valid are visible in the cycle after E. Back-to-back accepts every cycle are allowed.
- MUL accepted at edge E:
  - op_ready is low for WIDTH cycles.
  - res_valid is high in cycle E+WIDTH+1, and op_ready is high again in that same cycle.
- Operand writes during MUL change a_o/b_o immediately but do not affect the product, since operands are snapshotted at accept.
- ADC/SBC use the C value as of the accepting edge.

## Configuration
- GOOFY_ALU_MUL_EN defined: MUL is implemented as specified.
- GOOFY_ALU_MUL_EN undefined:
  - Opcode 12 behaves as reserved (res_valid pulse only).
  - result_hi is tied to 0.
  - The MUL state and sub-module are absent, so op_ready depends only on flag_hlt.

## Structure
- goofy_alu_pkg holds:
  - the opcode enum and opcode width;
  - the FSM state typedef;
  - a flag-bundle struct {c, z, eq, hlt}.
- Sub-module goofy_alu_mul: start/operands in, WIDTH-cycle iterative multiplier with done pulse and 2·WIDTH product. Instantiated only under GOOFY_ALU_MUL_EN.

## Test plan
All scenarios use WIDTH = 8.
- ADD A=0xF0, B=0x20 → result 0x10, C=1, Z=0, one res_valid pulse. Then ADC A=0x01, B=0x01 → 0x03, C=0.
- SUB A=0x05, B=0x07 → 0xFE, C=1. Then CMP A=B=0x42 → eq=1, C=0, result stays 0xFE.
- MUL A=0xFF, B=0xFF with a_we of 0x00 two cycles after accept → result_hi 0xFE, result 0x01, C=1. op_ready low 8 cycles, res_valid in cycle accept+9.
- HLT, then op_valid held with ADD → op_ready=0 and no accept. Pulse flag_clr → op_ready=1 next cycle, ADD accepted.
- SHL A=0x81, B=0x09 → shift by 1 → 0x02, C=1. SHR A=0x81, B=0x00 → 0x81, C=0.
- Assert res low 3 cycles into MUL → all outputs 0 immediately, no res_valid. After release, op_ready=1 and ADD 0x01+0x01 → 0x02.
